// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StError
  } state_e;

  localparam logic [4:0]  XZR             = 5'd31;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: load-use stalls, branch flushes, memory-wait freeze with timeout,
// and saturating stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rm,
  input  logic [4:0]       ex_rd,
  input  logic             ex_readmem,
  input  logic             ex_regwri,
  input  logic             ex_brtaken,
  input  logic             ex_br,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WaitW    = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             load_use, branch, mem_stall;
  logic             stall_inc, flush_inc;

  assign load_use  = ex_readmem & ex_regwri & (ex_rd != XZR) &
                     ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));
  assign branch    = ex_brtaken | ex_br;
  assign mem_stall = mem_access & ~mem_ready;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    mem_err    = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          // The first frozen cycle is spent in RUN and counts as a stall.
          stall_inc = 1'b1;
          wait_d    = '0;
          state_d   = StMemWait;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          if (branch) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end
        end
      end
      StMemWait: begin
        stall_inc = 1'b1;
        if (mem_ready) begin
          wait_d  = '0;
          state_d = StRun;
        end else if (wait_q == WaitLast) begin
          state_d = StError;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StError: begin
        mem_err = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .inc_i   (stall_inc),
    .count_o (stall_cnt)
  );

  sat_counter #(
    .Width (CNT_W)
  ) u_flush_cnt (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .inc_i   (flush_inc),
    .count_o (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (default instance plus a CNT_W=4 instance).
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rn, id_rm, ex_rd;
  logic        id_uses_rm, ex_readmem, ex_regwri, ex_brtaken, ex_br, mem_access, mem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mem_err;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
  logic        ifid_flush4, idex_flush4, mem_err4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int total = 0;
  int bad   = 0;

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_readmem(ex_readmem), .ex_regwri(ex_regwri), .ex_brtaken(ex_brtaken),
    .ex_br(ex_br), .mem_access(mem_access), .mem_ready(mem_ready), .pc_en(pc_en),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_readmem(ex_readmem), .ex_regwri(ex_regwri), .ex_brtaken(ex_brtaken),
    .ex_br(ex_br), .mem_access(mem_access), .mem_ready(mem_ready), .pc_en(pc_en4),
    .ifid_en(ifid_en4), .idex_en(idex_en4), .exmem_en(exmem_en4), .memwb_en(memwb_en4),
    .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .mem_err(mem_err4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Packed view of the seven control outputs: {pc,ifid,idex,exmem,memwb,ifid_fl,idex_fl}.
  function automatic logic [31:0] ctl();
    return {25'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rn = 5'd0; id_rm = 5'd0; id_uses_rm = 1'b0; ex_rd = 5'd0;
    ex_readmem = 1'b0; ex_regwri = 1'b0; ex_brtaken = 1'b0; ex_br = 1'b0;
    mem_access = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    chk("reset_ctl", ctl(), 32'b1111100);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_flush", flush_cnt, 0);
    chk("reset_err", mem_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on Rn
    ex_readmem = 1'b1; ex_regwri = 1'b1; ex_rd = 5'd5; id_rn = 5'd5;
    #1;
    chk("lu_rn_ctl", ctl(), 32'b0011101);
    tick();
    idle();
    #1;
    chk("lu_rn_stall", stall_cnt, 1);
    chk("lu_after_ctl", ctl(), 32'b1111100);

    // Load-use on Rm only when id_uses_rm
    ex_readmem = 1'b1; ex_regwri = 1'b1; ex_rd = 5'd7; id_rn = 5'd2; id_rm = 5'd7;
    #1;
    chk("rm_unused_ctl", ctl(), 32'b1111100);
    id_uses_rm = 1'b1;
    #1;
    chk("rm_used_ctl", ctl(), 32'b0011101);
    tick();
    idle();
    #1;
    chk("rm_stall", stall_cnt, 2);

    // XZR never hazards
    ex_readmem = 1'b1; ex_regwri = 1'b1; ex_rd = 5'd31; id_rn = 5'd31;
    #1;
    chk("xzr_ctl", ctl(), 32'b1111100);
    tick();
    chk("xzr_stall", stall_cnt, 2);

    // Branch beats load-use
    do_reset();
    ex_readmem = 1'b1; ex_regwri = 1'b1; ex_rd = 5'd5; id_rn = 5'd5; ex_brtaken = 1'b1;
    #1;
    chk("br_lu_ctl", ctl(), 32'b1111111);
    tick();
    idle();
    chk("br_lu_flush", flush_cnt, 1);
    chk("br_lu_stall", stall_cnt, 0);
    ex_br = 1'b1;
    #1;
    chk("brreg_ctl", ctl(), 32'b1111111);
    tick();
    idle();
    chk("brreg_flush", flush_cnt, 2);

    // Memory wait: ready low 3 cycles, then high; memory beats branch
    do_reset();
    mem_access = 1'b1; ex_brtaken = 1'b1;
    #1;
    chk("mw_c1_ctl", ctl(), 32'b0000000);
    tick();
    chk("mw_c2_ctl", ctl(), 32'b0000000);
    tick();
    chk("mw_c3_ctl", ctl(), 32'b0000000);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("mw_c4_ctl", ctl(), 32'b0000000);
    tick();
    chk("mw_stall", stall_cnt, 4);
    chk("mw_run_br_ctl", ctl(), 32'b1111111);
    chk("mw_flush0", flush_cnt, 0);
    idle();
    #1;
    chk("mw_run_ctl", ctl(), 32'b1111100);

    // Timeout into ERROR
    do_reset();
    mem_access = 1'b1;
    tick();
    repeat (254) tick();
    chk("to_pre_err", mem_err, 0);
    chk("to_pre_ctl", ctl(), 32'b0000000);
    tick();
    chk("to_err", mem_err, 1);
    chk("to_err_ctl", ctl(), 32'b0000000);
    chk("to_stall", stall_cnt, 256);
    mem_ready = 1'b1;
    tick();
    chk("to_sticky", mem_err, 1);
    chk("to_stall_hold", stall_cnt, 256);
    idle();
    rst_n = 1'b0;
    #1;
    chk("to_rst_err", mem_err, 0);
    chk("to_rst_stall", stall_cnt, 0);
    chk("to_rst_flush", flush_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("to_rst_ctl", ctl(), 32'b1111100);

    // Reset in the middle of MEM_WAIT
    do_reset();
    mem_access = 1'b1;
    tick();
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", stall_cnt, 0);
    chk("mid_rst_ctl", ctl(), 32'b1111100);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_run", ctl(), 32'b1111100);

    // Saturation with a 4-bit counter
    do_reset();
    ex_brtaken = 1'b1;
    repeat (20) tick();
    chk("sat4_flush", flush_cnt4, 15);
    chk("sat16_flush", flush_cnt, 20);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
